mul_rnd_sat_p: RTL
==================

Name: mul_rnd_sat_p

Overview:
- Parametrised, pipelined signed multiplier for the LO-mixing and gain paths. Supersedes the fixed 19x18->18 multiplier.
- Computes A*B at full precision, then applies a run-time-selectable rounding mode: truncate, round-half-up or convergent.
- Extracts a PW-bit output window, and either saturates or wraps on overflow.
- Carries a valid strobe and a channel tag, so several time-multiplexed channels can share one instance.
- Provides a clock enable and a sticky overflow flag.

Parameters:
- AW, 19, width of signed input A (LO/coefficient).
- BW, 18, width of signed input B (RF/IF data).
- PW, 18, width of signed output P.
- SHIFT, 18, number of product LSBs discarded. Legal range is 1..AW+BW-PW. The default drops the redundant product sign bit.
- SAT, 1, 1 = saturate on overflow; 0 = wrap (plain window slice).
- TW, 2, width of the channel tag.

Ports:
- clk  in  1  master clock; all state updates on the rising edge.
- rst  in  1  master reset, asynchronous, active-low.
- ce  in  1  clock enable. When 0, every pipeline register, vout and the sticky flag hold.
- vin  in  1  input sample valid.
- tin  in  TW  channel tag, travels with the sample.
- mode  in  2  rounding mode, sampled with the data: 00 truncate, 01 half-up, 10 convergent, 11 treated as 01.
- A  in  AW  signed multiplicand.
- B  in  BW  signed multiplier.
- P  out  PW  rounded, saturated or wrapped product.
- vout  out  1  output valid.
- tout  out  TW  tag of the sample on P.
- V  out  1  per-sample overflow, qualified by vout.
- clr  in  1  clears the sticky overflow flag.
- ovf_sticky  out  1  set by any valid overflowed sample.

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers go to 0, including P, vout, tout, V and ovf_sticky. Reset mid-stream discards all in-flight samples. The first vout after release is 4 ce-cycles after the first vin.
- Pipeline: 4 stages, advancing only on cycles with ce=1.
  - S1: register A, B, vin, tin, mode.
  - S2: register the full signed product F, FW=AW+BW bits.
  - S3: register R = sign-extended F (FW+1 bits) + offset.
    - truncate: offset = 0.
    - half-up: offset = 2^(SHIFT-1).
    - convergent: offset = 2^(SHIFT-1) - 1 + F[SHIFT]. Ties go to the even result.
  - S4: register P, V, vout, tout.
- Latency: 4 enabled cycles. Throughput is one sample per enabled cycle. There is no backpressure.
- Overflow: ov = 1 when bits R[FW:SHIFT+PW-1] are not all equal, i.e. the result is not representable in PW signed bits.
- Output selection:
  - ov=0: P = R[SHIFT+PW-1:SHIFT].
  - ov=1, SAT=1: P = max positive (0 followed by ones) if R[FW]=0, else min negative (1 followed by zeros).
  - ov=1, SAT=0: P = R[SHIFT+PW-1:SHIFT] (wrapped).
- V = ov, gated with the S3 valid bit, so V=0 whenever vout=0.
- Samples with vin=0 still propagate data. Their vout=0 and V=0, and P is don't-care but deterministic.
- Sticky flag:
  - Set on an enabled cycle where S4 latches a valid overflow.
  - Cleared by clr=1 on an enabled cycle.
  - If set and clear occur in the same cycle, set wins.
  - When ce=0, clr has no effect.
- Mode, tag and valid travel with their sample. A mode change takes effect on the exact sample presented with it; there is no cross-sample contamination.
- Defaults (AW=19, BW=18, PW=18, SHIFT=18, SAT=1) yield P = F[35:18], rounded. This is bit-compatible with the earlier 19x18 block for half-up mode and non-overflowing inputs.
- Width rules: all arithmetic is signed two's complement. The full product is never truncated before rounding.

Test Plan:
- Latency and tag: one-cycle vin=1, A=131072, B=65536, mode=01, tin=2, ce=1. Response: exactly 4 cycles later vout=1, P=32768, tout=2, V=0; vout=0 on all other cycles.
- Rounding ties, in order: A=1, B=131072 (+0.5 LSB); A=3, B=131072 (+1.5 LSB); A=-1, B=131072 (-0.5 LSB). Response:
  - truncate: P = 0, 1, -1.
  - half-up: P = 1, 2, 0.
  - convergent: P = 0, 2, 0.
- Overflow: A=-262144, B=-131072 (F=2^35). Response with SAT=1: P=131071, V=1, ovf_sticky=1. Response with a second SAT=0 instance: P=-131072, V=1.
- Sticky and clear: an overflow sample, then clr=1 in the same cycle as a second overflow reaches S4. Response: ovf_sticky stays 1. A later clr with no overflow gives 0 the following cycle.
- Clock enable: a stream of 6 back-to-back samples, with ce=0 for 3 cycles in the middle. Response: outputs and ovf_sticky frozen during the stall. All 6 results appear in order, each after 4 enabled cycles, with none lost or duplicated.
- Reset mid-stream: rst=0 while 3 samples are in flight. Response: vout, P, V and ovf_sticky go to 0 immediately (asynchronous). No stale samples emerge after release.

Source files
------------

// File: rtl/mul_rnd_sat_p.sv
// rtl/mul_rnd_sat_p.sv - pipelined signed multiplier with selectable rounding and saturation
module mul_rnd_sat_p #(
  parameter int AW    = 19,
  parameter int BW    = 18,
  parameter int PW    = 18,
  parameter int SHIFT = 18,
  parameter int SAT   = 1,
  parameter int TW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 vin,
  input  logic [TW-1:0]        tin,
  input  logic [1:0]           mode,
  input  logic signed [AW-1:0] A,
  input  logic signed [BW-1:0] B,
  output logic signed [PW-1:0] P,
  output logic                 vout,
  output logic [TW-1:0]        tout,
  output logic                 V,
  input  logic                 clr,
  output logic                 ovf_sticky
);

  localparam int FW = AW + BW;
  // Bits R[FW:SHIFT+PW-1] must all match for the window to be representable.
  localparam int HW = FW - SHIFT - PW + 2;
  localparam logic [FW:0] ONE  = (FW+1)'(1);
  localparam logic [FW:0] HALF = ONE << (SHIFT - 1);

  logic signed [AW-1:0] a1;
  logic signed [BW-1:0] b1;
  logic                 v1, v2, v3;
  logic [TW-1:0]        t1, t2, t3;
  logic [1:0]           m1, m2;
  logic signed [FW-1:0] f2;
  logic [FW:0]          r3;

  logic [FW:0]   f_ext;
  logic [FW:0]   ofs;
  logic [HW-1:0] hi;
  logic          ov;
  logic [PW-1:0] p_next;
  logic          unused_lsbs;

  always_comb begin
    f_ext = {f2[FW-1], f2};
    ofs   = '0;
    case (m2)
      2'b00:   ofs = '0;
      2'b10:   ofs = HALF - ONE + {{FW{1'b0}}, f2[SHIFT]};
      default: ofs = HALF;
    endcase
  end

  always_comb begin
    hi     = r3[FW -: HW];
    ov     = !((&hi) || !(|hi));
    p_next = r3[SHIFT+PW-1:SHIFT];
    if (ov && (SAT != 0))
      p_next = r3[FW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  end

  // Rounding has already folded the discarded LSBs into the kept window.
  assign unused_lsbs = ^r3[SHIFT-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1         <= '0;
      b1         <= '0;
      v1         <= 1'b0;
      t1         <= '0;
      m1         <= '0;
      f2         <= '0;
      v2         <= 1'b0;
      t2         <= '0;
      m2         <= '0;
      r3         <= '0;
      v3         <= 1'b0;
      t3         <= '0;
      P          <= '0;
      V          <= 1'b0;
      vout       <= 1'b0;
      tout       <= '0;
      ovf_sticky <= 1'b0;
    end else if (ce) begin
      a1   <= A;
      b1   <= B;
      v1   <= vin;
      t1   <= tin;
      m1   <= mode;
      f2   <= FW'(a1) * FW'(b1);
      v2   <= v1;
      t2   <= t1;
      m2   <= m1;
      r3   <= f_ext + ofs;
      v3   <= v2;
      t3   <= t2;
      P    <= p_next;
      V    <= ov & v3;
      vout <= v3;
      tout <= t3;
      if (v3 && ov)
        ovf_sticky <= 1'b1;
      else if (clr)
        ovf_sticky <= 1'b0;
    end
  end

endmodule
